adc_trigger_capture: RTL
========================

Name: adc_trigger_capture

Overview:
- Sits between adc_ltc2315 and the ADC→Ethernet fifo_acp, in the ADC clock domain.
- Watches the 12-bit sample stream for a sample-to-sample step larger than a host-supplied threshold.
- On a trigger, freezes a pre/post-trigger window in a circular buffer, then drains the whole window as one 256-word frame, ready for the Ethernet packetiser.

Parameters:
- PRE_LEN, 64, samples kept before the trigger sample.
- POST_LEN, 192, samples captured from the trigger sample onward; PRE_LEN+POST_LEN must equal 2**ADDR_W.
- ADDR_W, 8, circular buffer address width (256 words).

Ports:
- clk_100  in  1  ADC-domain clock (clk_dv net).
- reset  in  1  synchronous, active-high.
- start  in  1  level; 1 = capture enabled, 0 = stop after any frame in progress.
- adc_en  in  1  one-cycle strobe: adc_data valid.
- adc_data  in  16  sample; only [11:0] used (unsigned code).
- porog  in  16  step threshold; 0 disables triggering.
- out_data  out  16  frame word, {4'd0, sample[11:0]}.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word when out_valid&out_ready.
- frame_start  out  1  high with the first word of a frame.
- frame_end  out  1  high with the last (256th) word.
- armed  out  1  state==ARMED.
- busy  out  1  state is POST or DRAIN.
- trig_cnt  out  16  frames triggered since reset; wraps 0xFFFF→0.
- drop_cnt  out  16  adc_en strobes discarded during DRAIN; saturates at 0xFFFF.

Behaviour:
- Reset (sync, synchronous to clk_100): state IDLE; wr_ptr=0, fill_cnt=0, prev_valid=0; all outputs 0.
- Step detection:
  - diff = {1'b0,sample} - {1'b0,prev}, 13-bit signed; mag = |diff| (12-bit).
  - hit = prev_valid & (porog!=0) & (porog[15:12]==0) & (mag > porog[11:0]), evaluated on the adc_en cycle.
  - prev updates on every accepted sample.
  - prev_valid clears in IDLE and DRAIN; it sets on the first sample accepted in FILL.
- Buffer write: on adc_en in FILL/ARMED/POST, write sample to buf[wr_ptr]; wr_ptr increments mod 2**ADDR_W.
- FSM:
  - IDLE: start=1 → FILL, with fill_cnt=0.
  - FILL: count accepted samples; hits ignored. Reaching fill_cnt==PRE_LEN → ARMED.
  - ARMED: hit → POST. The triggering sample is post sample #0; trig_addr = its write address; post_cnt=1; trig_cnt+1. start=0 → IDLE.
  - POST: capture until post_cnt==POST_LEN (last sample written) → DRAIN. Further hits are ignored. start=0 does not abort.
  - DRAIN:
    - Read address starts at (trig_addr - PRE_LEN) mod 2**ADDR_W and increments on each accepted word.
    - Sync-read RAM: out_valid may rise 1 cycle after DRAIN entry.
    - out_data/out_valid hold stable while out_valid&~out_ready.
    - After the 256th handshake → FILL if start=1, else IDLE (fill restarts from 0).
- Each adc_en in DRAIN increments drop_cnt; the sample is not written.
- Samples arriving in IDLE are ignored; they are not counted.
- Simultaneous hit and start fall in ARMED: the hit wins → POST.
- Wrap: the read address wraps modulo the buffer depth; the frame never contains stale data because FILL guarantees PRE_LEN valid pre-samples.
- frame_start/frame_end are qualified by out_valid; they are held with it under backpressure.

Optional Feature:
- Macro TRIG_EXTERNAL_EN.
- Defined: adds input ext_trig (1 bit, level, sampled on adc_en). In ARMED, adc_en & ext_trig triggers exactly as a hit, even when porog=0.
- Undefined: no port; only the step detector triggers.

Test Plan:
- Basic capture:
  - Stimulus: reset, start=1, porog=100, adc_en every 4 cycles, ramp data 0,1,2…; at sample index 300 inject a step to 0x800.
  - Response: armed rises after 64 samples; trig_cnt=1; 256 words emitted; word 0 is 236, word 63 is 299, word 64 is 0x800.
- Threshold boundary:
  - Stimulus: porog=50, steps of exactly +50 and then +51.
  - Response: no trigger on +50; trigger on +51.
  - Negative step -51 also triggers; porog=0 or 0x1000 never triggers.
- Backpressure:
  - Stimulus: during DRAIN, out_ready toggles 1,0,0,1.
  - Response: out_data and frame_start stay stable while stalled; exactly 256 handshakes; frame_end on the last handshake only.
- Drops and re-arm:
  - Stimulus: 10 adc_en strobes during DRAIN.
  - Response: drop_cnt=10. After drain, with start=1: FILL again, armed after 64 new samples; a step during FILL does not trigger.
- Stop and reset:
  - start=0 in POST: frame still completes, then IDLE.
  - reset asserted mid-DRAIN: next cycle out_valid=0, trig_cnt=0, state IDLE.
- TRIG_EXTERNAL_EN:
  - Stimulus: porog=0, ext_trig=1 on a sample while ARMED.
  - Response: frame is captured; trig_cnt=1.

Source files
------------

// File: rtl/adc_trigger_capture.sv
// Step-triggered pre/post window capture of the 12-bit ADC stream, drained as one 2**ADDR_W-word frame.
// Define TRIG_EXTERNAL_EN to add the ext_trig input (level, sampled on adc_en, triggers while ARMED).
module adc_trigger_capture #(
  parameter int PRE_LEN  = 64,
  parameter int POST_LEN = 192,
  parameter int ADDR_W   = 8
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        start,
  input  logic        adc_en,
  input  logic [15:0] adc_data,
  input  logic [15:0] porog,
`ifdef TRIG_EXTERNAL_EN
  input  logic        ext_trig,
`endif
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_start,
  output logic        frame_end,
  output logic        armed,
  output logic        busy,
  output logic [15:0] trig_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DRAIN} state_t;

  localparam logic [ADDR_W:0]   PRE_CNT  = (ADDR_W+1)'(PRE_LEN);
  localparam logic [ADDR_W:0]   POST_CNT = (ADDR_W+1)'(POST_LEN);
  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_LEN);

  state_t            r_state, w_state_nx;
  logic [11:0]       r_mem [2**ADDR_W];
  logic [11:0]       r_q;
  logic [11:0]       r_prev;
  logic              r_prev_valid;
  logic [ADDR_W-1:0] r_wr_ptr, r_trig_addr, r_rd_addr, r_out_cnt;
  logic [ADDR_W:0]   r_fill_cnt, r_post_cnt;
  logic              r_out_valid;
  logic [15:0]       r_trig_cnt, r_drop_cnt;

  logic [11:0]       w_sample, w_mag;
  logic [12:0]       w_diff, w_neg;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_hit, w_trig, w_accept, w_hs, w_last;
  logic              w_fill_done, w_post_done, w_unused;

  assign w_sample = adc_data[11:0];
  assign w_unused = ^adc_data[15:12];

  // Magnitude of the signed 13-bit step between consecutive accepted samples.
  assign w_diff = {1'b0, w_sample} - {1'b0, r_prev};
  assign w_neg  = 13'd0 - w_diff;
  assign w_mag  = w_diff[12] ? w_neg[11:0] : w_diff[11:0];
  assign w_hit  = r_prev_valid && (porog != 16'd0) && (porog[15:12] == 4'd0)
                  && (w_mag > porog[11:0]);
`ifdef TRIG_EXTERNAL_EN
  assign w_trig = w_hit || ext_trig;
`else
  assign w_trig = w_hit;
`endif

  assign w_accept    = adc_en && (r_state == FILL || r_state == ARMED || r_state == POST);
  assign w_fill_done = adc_en && (r_fill_cnt == PRE_CNT - 1'b1);
  assign w_post_done = adc_en && (r_post_cnt == POST_CNT - 1'b1);
  assign w_hs        = r_out_valid && out_ready;
  assign w_last      = &r_out_cnt;
  assign w_rd_addr   = w_hs ? r_rd_addr + 1'b1 : r_rd_addr;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_100) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // NOTE: default assigned first so no path leaves w_state_nx unassigned (no latch).
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = FILL;
      FILL:    if (w_fill_done) w_state_nx = ARMED;
      ARMED:   if (adc_en && w_trig) w_state_nx = POST;
               else if (!start)      w_state_nx = IDLE;
      POST:    if (w_post_done) w_state_nx = DRAIN;
      DRAIN:   if (w_hs && w_last) w_state_nx = start ? FILL : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // NOTE: the sample RAM has no reset; a frame only reads words written since the last FILL.
  always_ff @(posedge clk_100) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_sample;
    r_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wr_ptr     <= '0;
      r_trig_addr  <= '0;
      r_rd_addr    <= '0;
      r_out_cnt    <= '0;
      r_fill_cnt   <= '0;
      r_post_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_trig_cnt   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_prev       <= w_sample;
        r_prev_valid <= 1'b1;
        r_wr_ptr     <= r_wr_ptr + 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_prev_valid <= 1'b0;
          r_fill_cnt   <= '0;
        end
        FILL: if (adc_en) r_fill_cnt <= r_fill_cnt + 1'b1;
        ARMED: if (adc_en && w_trig) begin
          r_trig_addr <= r_wr_ptr;
          r_post_cnt  <= {{ADDR_W{1'b0}}, 1'b1};
          r_trig_cnt  <= r_trig_cnt + 1'b1;
        end
        POST: if (adc_en) begin
          r_post_cnt <= r_post_cnt + 1'b1;
          if (w_post_done) begin
            r_rd_addr <= r_trig_addr - PRE_OFS;
            r_out_cnt <= '0;
          end
        end
        DRAIN: begin
          r_prev_valid <= 1'b0;
          if (adc_en && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
          // Output word stays put while stalled: the RAM keeps reading r_rd_addr.
          r_out_valid <= !(w_hs && w_last);
          if (w_hs) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            r_out_cnt <= r_out_cnt + 1'b1;
            if (w_last) r_fill_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_valid ? {4'd0, r_q} : 16'd0;
  assign frame_start = r_out_valid && (r_out_cnt == '0);
  assign frame_end   = r_out_valid && w_last;
  assign armed       = (r_state == ARMED);
  assign busy        = (r_state == POST) || (r_state == DRAIN);
  assign trig_cnt    = r_trig_cnt;
  assign drop_cnt    = r_drop_cnt;

endmodule
